// File: rtl/playfield_row_store.sv
// Playfield row store: one WIDTH-bit bitmap row per playfield line, CPU row
// writes, 1-cycle-latency graphics reads and an in-place line-clear engine
// that drops full rows, packs survivors toward the bottom and zero-fills the top.
// Optional feature macro: ROW_STORE_TOPOUT_EN adds the sticky top_out flag.
module playfield_row_store #(
    parameter int ROWS  = 20,
    parameter int WIDTH = 10,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [31:0]      wr_data,
    output logic             wr_drop,
    input  logic [IDX_W-1:0] rd_index,
    output logic [31:0]      rd_data,
    input  logic             clear_req,
    output logic             clear_busy,
    output logic             clear_done,
    output logic [IDX_W-1:0] lines_cleared
`ifdef ROW_STORE_TOPOUT_EN
    ,
    output logic             top_out
`endif
);

    // state   | meaning
    // IDLE    | CPU writes accepted, waiting for clear_req
    // COMPACT | scan src from bottom to top, copy non-full rows down to dst
    // FILL    | zero rows dst..0 left empty by removed lines
    // DONE    | one-cycle completion pulse, publish lines_cleared
    typedef enum logic [1:0] {IDLE, COMPACT, FILL, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROWS - 1);

    state_t           state, next_state;
    logic [WIDTH-1:0] row_mem [ROWS];
    logic [IDX_W-1:0] src, dst, count, count_nxt;
    logic             src_full, accept_clear, wr_ok;
    logic             unused_bits;

    assign unused_bits = ^wr_data[31:WIDTH];

    assign src_full   = &row_mem[src];
    assign wr_ok      = wr_en && (state == IDLE) && !clear_req && (wr_index <= LAST);
    assign clear_busy = (state == COMPACT) || (state == FILL);
    assign clear_done = (state == DONE);

    // Next-state decode; count_nxt includes the row being judged this cycle
    always_comb begin
        next_state   = state;
        accept_clear = 1'b0;
        count_nxt    = count;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    accept_clear = 1'b1;
                    next_state   = COMPACT;
                end
            end
            COMPACT: begin
                if (src_full) count_nxt = count + IDX_W'(1);
                if (src == '0) next_state = (count_nxt != '0) ? FILL : DONE;
            end
            FILL: begin
                if (dst == '0) next_state = DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Pointers, removed-line count and the published result
    always_ff @(posedge clk) begin
        if (rst) begin
            src           <= '0;
            dst           <= '0;
            count         <= '0;
            lines_cleared <= '0;
        end else begin
            if (accept_clear) begin
                src           <= LAST;
                dst           <= LAST;
                count         <= '0;
                lines_cleared <= '0;
            end
            if (state == COMPACT) begin
                count <= count_nxt;
                if (src != '0) src <= src - IDX_W'(1);
                if (!src_full && dst != '0) dst <= dst - IDX_W'(1);
            end
            if (state == FILL && dst != '0) dst <= dst - IDX_W'(1);
            if (next_state == DONE) lines_cleared <= count_nxt;
        end
    end

    // Row array: CPU writes in IDLE, row moves in COMPACT, zero-fill in FILL
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) row_mem[i] <= '0;
        end else begin
            case (state)
                IDLE:    if (wr_ok) row_mem[wr_index] <= wr_data[WIDTH-1:0];
                COMPACT: if (!src_full) row_mem[dst] <= row_mem[src];
                FILL:    row_mem[dst] <= '0;
                default: ;
            endcase
        end
    end

    // Registered read port and write-reject pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            wr_drop <= 1'b0;
        end else begin
            rd_data <= (rd_index <= LAST) ? {{(32-WIDTH){1'b0}}, row_mem[rd_index]} : '0;
            wr_drop <= wr_en && !wr_ok;
        end
    end

`ifdef ROW_STORE_TOPOUT_EN
    // Sticky game-over flag: anything left in the top row while idle
    always_ff @(posedge clk) begin
        if (rst)                                   top_out <= 1'b0;
        else if (state == IDLE && row_mem[0] != '0) top_out <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_playfield_row_store.sv
// Self-checking bench for playfield_row_store with a row model and a read
// scoreboard. Define ROW_STORE_TOPOUT_EN to also exercise top_out.
module tb_playfield_row_store;

    logic        clk = 1'b0;
    logic        rst, wr_en, clear_req;
    logic [4:0]  wr_index, rd_index;
    logic [31:0] wr_data, rd_data;
    logic        wr_drop, clear_busy, clear_done;
    logic [4:0]  lines_cleared;
`ifdef ROW_STORE_TOPOUT_EN
    logic        top_out;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  mdl [20];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    playfield_row_store dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .wr_drop(wr_drop), .rd_index(rd_index), .rd_data(rd_data), .clear_req(clear_req),
        .clear_busy(clear_busy), .clear_done(clear_done), .lines_cleared(lines_cleared)
`ifdef ROW_STORE_TOPOUT_EN
        , .top_out(top_out)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rd_index = 5'(i);
            exp_q.push_back((i < 20) ? {22'd0, mdl[i]} : 32'd0);
            tick();
            check_val($sformatf("rd_row%0d", i), rd_data, exp_q.pop_front());
        end
    endtask

    task automatic write_row(input int idx, input logic [31:0] data);
        wr_en    = 1'b1;
        wr_index = 5'(idx);
        wr_data  = data;
        tick();
        wr_en = 1'b0;
        check_val($sformatf("wr_drop%0d", idx), {31'd0, wr_drop}, (idx < 20) ? 32'd0 : 32'd1);
        if (idx < 20) mdl[idx] = data[9:0];
    endtask

    task automatic model_clear();
        logic [9:0] tmp [20];
        int k;
        for (int i = 0; i < 20; i++) tmp[i] = '0;
        k = 19;
        for (int s = 19; s >= 0; s--) begin
            if (mdl[s] != 10'h3FF) begin
                tmp[k] = mdl[s];
                k--;
            end
        end
        for (int i = 0; i < 20; i++) mdl[i] = tmp[i];
    endtask

    // inject_at > 0: on that cycle a write to row 3 and a second clear_req are driven
    task automatic run_clear(input string tag, input int exp_lines, input int inject_at);
        int n, extra;
        bit seen;
        n = 0; seen = 0; extra = 0;
        model_clear();
        while (n < 100 && !seen) begin
            clear_req = (n == 0) || (n == inject_at);
            wr_en     = (n == inject_at);
            wr_index  = 5'd3;
            wr_data   = 32'h3FF;
            tick();
            n++;
            clear_req = 1'b0;
            wr_en     = 1'b0;
            if (n == 1) check_val({tag, "_busy"}, {31'd0, clear_busy}, 32'd1);
            if (inject_at > 0 && n == inject_at + 1)
                check_val({tag, "_inj_drop"}, {31'd0, wr_drop}, 32'd1);
            if (clear_done) seen = 1;
        end
        if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
        check_val({tag, "_latency"}, n, 21 + exp_lines);
        check_val({tag, "_lines"}, {27'd0, lines_cleared}, exp_lines);
        check_val({tag, "_busy_done"}, {31'd0, clear_busy}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (clear_done) extra++;
        end
        check_val({tag, "_single_done"}, extra, 32'd0);
        check_val({tag, "_lines_hold"}, {27'd0, lines_cleared}, exp_lines);
        read_rows(0, 19);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; clear_req = 1'b0;
        wr_index = '0; rd_index = '0; wr_data = '0;
        for (int i = 0; i < 20; i++) mdl[i] = '0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_rd", rd_data, 32'd0);
        check_val("rst_flags", {29'd0, wr_drop, clear_busy, clear_done}, 32'd0);
        check_val("rst_lines", {27'd0, lines_cleared}, 32'd0);
        read_rows(0, 19);

        write_row(19, 32'hFFFF_F155);
        read_rows(19, 19);
        check_val("row19_value", rd_data, 32'h0000_0155);
        write_row(20, 32'h0000_03FF);
        write_row(31, 32'h0000_0001);
        read_rows(0, 21);

        // same-cycle write and read of row 19 returns the old contents
        rd_index = 5'd19;
        wr_en = 1'b1; wr_index = 5'd19; wr_data = 32'h0AA;
        tick();
        wr_en = 1'b0;
        check_val("wr_rd_old", rd_data, 32'h155);
        mdl[19] = 10'h0AA;
        tick();
        check_val("wr_rd_new", rd_data, 32'h0AA);

        write_row(19, 32'h3FF);
        write_row(18, 32'h3FF);
        write_row(17, 32'h001);
        write_row(16, 32'h200);
        run_clear("clr_adj", 2, 0);
        check_val("adj_row19", {22'd0, mdl[19]}, 32'h001);
        check_val("adj_row18", {22'd0, mdl[18]}, 32'h200);

        write_row(19, 32'h3FF);
        write_row(17, 32'h3FF);
        write_row(18, 32'h0F0);
        write_row(16, 32'h000);
        run_clear("clr_gap", 2, 0);
        check_val("gap_row19", {22'd0, mdl[19]}, 32'h0F0);

        run_clear("clr_none", 0, 0);

        write_row(19, 32'h3FF);
        write_row(10, 32'h155);
        write_row(3, 32'h0AA);
        run_clear("clr_inject", 1, 5);

        for (int i = 0; i < 20; i++) write_row(i, 32'h3FF);
        run_clear("clr_full", 20, 0);

        // reset in the middle of FILL aborts and empties the playfield
        for (int i = 0; i < 20; i++) write_row(i, 32'h3FF);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (24) tick();
        check_val("fill_busy", {31'd0, clear_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) mdl[i] = '0;
        check_val("abort_busy", {31'd0, clear_busy}, 32'd0);
        check_val("abort_done", {31'd0, clear_done}, 32'd0);
        check_val("abort_lines", {27'd0, lines_cleared}, 32'd0);
        read_rows(0, 19);

`ifdef ROW_STORE_TOPOUT_EN
        check_val("top_rst", {31'd0, top_out}, 32'd0);
        write_row(0, 32'h010);
        check_val("top_early", {31'd0, top_out}, 32'd0);
        tick();
        check_val("top_set", {31'd0, top_out}, 32'd1);
        run_clear("clr_top", 0, 0);
        check_val("top_row0", {22'd0, mdl[0]}, 32'd0);
        check_val("top_sticky", {31'd0, top_out}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("top_cleared", {31'd0, top_out}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
